// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: rebuilds VGA coordinates from the syncs, checks timing, locks, and reports a per-frame lit count and probe colour
module vga_frame_monitor #(
    parameter logic [9:0] H_TOTAL     = 10'd800,
    parameter logic [9:0] V_TOTAL     = 10'd521,
    parameter logic [9:0] H_PULSE     = 10'd96,
    parameter logic [9:0] V_PULSE     = 10'd2,
    parameter logic [9:0] HBP         = 10'd144,
    parameter logic [9:0] HFP         = 10'd784,
    parameter logic [9:0] VBP         = 10'd31,
    parameter logic [9:0] VFP         = 10'd511,
    parameter logic [3:0] LOCK_FRAMES = 4'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  red,
    input  logic [2:0]  green,
    input  logic [1:0]  blue,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic        locked,
    output logic        sync_err,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        active,
    output logic [7:0]  probe_rgb,
    output logic        probe_valid,
    output logic [18:0] lit_count,
    output logic        frame_done
);
    typedef enum logic [1:0] {SEARCH, ACQ, LOCKED} state_t;
    state_t state, state_nx;
    logic hsync_q, vsync_q, seen_h, seen_v;
    logic hfall, vfall, hrise, vrise, err, timeout, act_nx;
    logic [9:0] hc_prev, vc_prev, hc_cur, vc_cur, x_cur, y_cur;
    logic [3:0] good_frames, good_nx;
    logic [18:0] lit_cnt;
    logic [7:0] rgb;

    // seen_h/seen_v mask checks until the first edge gives the counters a reference
    always_comb begin
        rgb = {red, green, blue};
        hfall = hsync_q & ~hsync;
        vfall = vsync_q & ~vsync;
        hrise = ~hsync_q & hsync;
        vrise = ~vsync_q & vsync;
        hc_cur = hfall ? 10'd0 : (&hc_prev) ? hc_prev : hc_prev + 10'd1;
        vc_cur = vfall ? 10'd0 : !hfall ? vc_prev : (&vc_prev) ? vc_prev : vc_prev + 10'd1;
        err = state != SEARCH &&
              ((seen_h && ((hfall && hc_prev != H_TOTAL - 10'd1) || (hrise && hc_cur != H_PULSE))) ||
               (seen_v && ((vfall && (vc_prev != V_TOTAL - 10'd1 || !hfall)) || (vrise && vc_cur != V_PULSE))));
        timeout = &hc_cur;
        state_nx = timeout ? SEARCH :
                   state == SEARCH ? (vfall ? ACQ : SEARCH) :
                   err ? ACQ :
                   (state == ACQ && vfall && good_frames + 4'd1 >= LOCK_FRAMES) ? LOCKED : state;
        good_nx = (timeout || err || state == SEARCH) ? 4'd0 :
                  (state == ACQ && vfall) ? good_frames + 4'd1 : good_frames;
        x_cur = hc_cur - HBP;
        y_cur = vc_cur - VBP;
        act_nx = state_nx == LOCKED && hc_cur >= HBP && hc_cur < HFP && vc_cur >= VBP && vc_cur < VFP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SEARCH;
            good_frames <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            seen_h      <= 1'b0;
            seen_v      <= 1'b0;
            hc_prev     <= '0;
            vc_prev     <= '0;
            lit_cnt     <= '0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
            x           <= '0;
            y           <= '0;
            active      <= 1'b0;
            probe_rgb   <= '0;
            probe_valid <= 1'b0;
            lit_count   <= '0;
            frame_done  <= 1'b0;
        end else begin
            sync_err    <= 1'b0;
            probe_valid <= 1'b0;
            frame_done  <= 1'b0;
            if (pix_en) begin
                hsync_q     <= hsync;
                vsync_q     <= vsync;
                seen_h      <= seen_h | hfall;
                seen_v      <= seen_v | vfall;
                hc_prev     <= hc_cur;
                vc_prev     <= vc_cur;
                state       <= state_nx;
                good_frames <= good_nx;
                locked      <= state_nx == LOCKED;
                sync_err    <= err;
                active      <= act_nx;
                if (act_nx) begin
                    x <= x_cur;
                    y <= y_cur;
                end
                if (act_nx && x_cur == probe_x && y_cur == probe_y) begin
                    probe_rgb   <= rgb;
                    probe_valid <= 1'b1;
                end
                // a vfall that stays locked closes the frame; one that enters lock only restarts the count
                if (state_nx != LOCKED || vfall)
                    lit_cnt <= '0;
                else if (act_nx && rgb != 8'd0)
                    lit_cnt <= lit_cnt + 19'd1;
                if (state == LOCKED && state_nx == LOCKED && vfall) begin
                    lit_count  <= lit_cnt;
                    frame_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb_vga_frame_monitor: scripted and random frames on a reduced raster, checked against a frame-level model
module tb_vga_frame_monitor;
    localparam int HT = 40, VT = 24, HP = 4, VP = 2, HB = 8, HF = 36, VB = 4, VF = 20;
    localparam int AW = HF - HB, AH = VF - VB;

    typedef struct {
        int fl, rx, ry, rw, rh;
        logic [7:0] col;
        int px, py, fd, lit, lk;
    } frame_t;

    logic clk = 1'b0;
    logic rst, pix_en, hsync, vsync;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic [9:0] probe_x, probe_y, x, y;
    logic locked, sync_err, active, probe_valid, frame_done;
    logic [7:0] probe_rgb;
    logic [18:0] lit_count;

    int checks = 0, failures = 0;
    int need, prev_lit;
    int fd_cnt, lit_seen, se_cnt, pv_cnt, prgb, mism, lk_end;
    frame_t tbl[16];

    vga_frame_monitor #(
        .H_TOTAL(10'(HT)), .V_TOTAL(10'(VT)), .H_PULSE(10'(HP)), .V_PULSE(10'(VP)),
        .HBP(10'(HB)), .HFP(10'(HF)), .VBP(10'(VB)), .VFP(10'(VF)), .LOCK_FRAMES(4'd2)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue), .probe_x(probe_x), .probe_y(probe_y),
        .locked(locked), .sync_err(sync_err), .x(x), .y(y), .active(active),
        .probe_rgb(probe_rgb), .probe_valid(probe_valid), .lit_count(lit_count),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".locked"}, int'(locked), 0);
        check({tag, ".active"}, int'(active), 0);
        check({tag, ".xy"}, int'({x, y}), 0);
        check({tag, ".probe_rgb"}, int'(probe_rgb), 0);
        check({tag, ".lit_count"}, int'(lit_count), 0);
        check({tag, ".pulses"}, int'({sync_err, frame_done, probe_valid}), 0);
    endtask

    // random idle cycles with junk on the inputs must not disturb anything
    task automatic drive(input logic h, input logic v, input logic [7:0] rgb);
        while ($urandom_range(3) == 0) begin
            pix_en = 1'b0;
            hsync = 1'($urandom);
            vsync = 1'($urandom);
            {red, green, blue} = 8'($urandom);
            @(posedge clk);
            #1;
        end
        pix_en = 1'b1;
        hsync = h;
        vsync = v;
        {red, green, blue} = rgb;
        @(posedge clk);
        #1;
    endtask

    // one frame (or its first nl lines); line fl is one sample short
    task automatic send_frame(input int nl, input int fl, input int rx, input int ry, input int rw, input int rh,
                              input logic [7:0] col, input int px, input int py, input bit lk, input bit fd);
        bit lc, es, ef, ea, ep, win;
        int ax, ay, len;
        logic [7:0] rgb;
        fd_cnt = 0; se_cnt = 0; pv_cnt = 0; mism = 0; lit_seen = -1; prgb = -1;
        lc = lk;
        probe_x = 10'(px);
        probe_y = 10'(py);
        for (int vc = 0; vc < nl; vc++) begin
            len = (vc == fl) ? HT - 1 : HT;
            for (int hc = 0; hc < len; hc++) begin
                ax = hc - HB;
                ay = vc - VB;
                win = hc >= HB && hc < HF && vc >= VB && vc < VF;
                rgb = !win ? 8'($urandom) :
                      (ax >= rx && ax < rx + rw && ay >= ry && ay < ry + rh) ? col : 8'h00;
                drive(hc >= HP, vc >= VP, rgb);
                es = fl >= 0 && vc == fl + 1 && hc == 0;
                if (es) lc = 1'b0;
                ef = fd && vc == 0 && hc == 0;
                ea = lc && win;
                ep = ea && ax == px && ay == py;
                if (locked !== lc || active !== ea || (ea && (x !== 10'(ax) || y !== 10'(ay))) ||
                    sync_err !== es || frame_done !== ef || probe_valid !== ep)
                    mism++;
                se_cnt += int'(sync_err);
                fd_cnt += int'(frame_done);
                pv_cnt += int'(probe_valid);
                if (frame_done) lit_seen = int'(lit_count);
                if (probe_valid) prgb = int'(probe_rgb);
            end
        end
        lk_end = int'(locked);
    endtask

    // need = clean vfalls still required before lock; t_* < 0 means take the model's value
    task automatic run(input string tag, input frame_t f);
        bit fd, lk;
        int efd, elit, epv, eprgb;
        fd = need == 0;
        need = need > 0 ? need - 1 : 0;
        lk = need == 0;
        send_frame(VT, f.fl, f.rx, f.ry, f.rw, f.rh, f.col, f.px, f.py, lk, fd);
        elit = f.lit >= 0 ? f.lit : prev_lit;
        efd = f.fd >= 0 ? f.fd : int'(fd);
        prev_lit = f.col != 8'd0 ? f.rw * f.rh : 0;
        epv = int'(lk && !(f.fl >= 0 && f.py + VB > f.fl));
        eprgb = (f.px >= f.rx && f.px < f.rx + f.rw && f.py >= f.ry && f.py < f.ry + f.rh) ? int'(f.col) : 0;
        if (f.fl >= 0) need = 2;
        check({tag, ".trace_deviations"}, mism, 0);
        check({tag, ".frame_done"}, fd_cnt, efd);
        if (efd != 0) check({tag, ".lit_count"}, lit_seen, elit);
        check({tag, ".sync_err"}, se_cnt, int'(f.fl >= 0));
        check({tag, ".probe_valid"}, pv_cnt, epv);
        if (epv != 0) check({tag, ".probe_rgb"}, prgb, eprgb);
        check({tag, ".locked"}, lk_end, f.lk >= 0 ? f.lk : int'(need == 0));
    endtask

    initial begin
        frame_t f;
        tbl[0]  = '{-1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0};
        tbl[1]  = '{-1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0};
        tbl[2]  = '{-1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1};
        tbl[3]  = '{-1, 10, 4, 6, 5, 8'hFC, 12, 5, 1, 0, 1};
        tbl[4]  = '{-1, 5, 2, 10, 10, 8'hFF, 6, 3, 1, 30, 1};
        tbl[5]  = '{8, 0, 0, 0, 0, 8'h00, 0, 10, 1, 100, 0};
        tbl[6]  = '{-1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0};
        tbl[7]  = '{-1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1};
        tbl[8]  = '{-1, 0, 0, 3, 4, 8'h01, 27, 15, 1, 0, 1};
        tbl[9]  = '{-1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 12, 1};
        tbl[10] = '{-1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0};
        tbl[11] = '{-1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0};
        tbl[12] = '{-1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1};
        tbl[13] = '{-1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0};
        tbl[14] = '{-1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0};
        tbl[15] = '{-1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1};
        rst = 1'b1; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1;
        {red, green, blue} = 8'd0; probe_x = '0; probe_y = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        need = 3;
        prev_lit = 0;
        for (int i = 0; i < 10; i++) run($sformatf("tbl%0d", i), tbl[i]);
        // hsync stuck high: lock must drop exactly when the line counter saturates
        for (int k = 1; k <= 1023 - (HT - 1); k++) begin
            drive(1'b1, 1'b1, 8'($urandom));
            if (k == 1023 - HT) check("timeout.before", int'(locked), 1);
        end
        check("timeout.locked", int'(locked), 0);
        check("timeout.active", int'(active), 0);
        need = 3;
        for (int i = 10; i < 13; i++) run($sformatf("tbl%0d", i), tbl[i]);
        for (int i = 0; i < 12; i++) begin
            f.fl = $urandom_range(3) == 0 ? int'($urandom_range(5, VT - 3)) : -1;
            f.rx = $urandom_range(0, AW - 1);
            f.ry = $urandom_range(0, AH - 1);
            f.rw = $urandom_range(0, AW - f.rx);
            f.rh = $urandom_range(0, AH - f.ry);
            f.col = $urandom_range(4) == 0 ? 8'h00 : 8'($urandom);
            f.px = $urandom_range(0, AW - 1);
            f.py = $urandom_range(0, AH - 1);
            f.fd = -1; f.lit = -1; f.lk = -1;
            run($sformatf("rnd%0d", i), f);
        end
        // reset in the middle of a frame
        begin
            bit fd, lk;
            fd = need == 0;
            need = need > 0 ? need - 1 : 0;
            lk = need == 0;
            send_frame(10, -1, 2, 2, 5, 5, 8'h3C, 3, 3, lk, fd);
            check("partial.trace_deviations", mism, 0);
        end
        rst = 1'b1; pix_en = 1'b1; hsync = 1'b0; vsync = 1'b0; {red, green, blue} = 8'hFF;
        @(posedge clk);
        #1;
        check_zero("midreset");
        rst = 1'b0;
        need = 3;
        prev_lit = 0;
        for (int i = 13; i < 16; i++) run($sformatf("tbl%0d", i), tbl[i]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
